alu_pipe: RTL and testbench

Parametrised, pipelined integer ALU with valid/ready handshakes on input and output. It supports arithmetic, logic, shift and compare operations on WIDTH-bit operands. It returns result, status flags and an illegal-opcode error after a fixed latency of STAGES cycles. It is the next-generation datapath ALU for stream-style datapaths that need backpressure and flags.

---
 rtl/alu_pipe.sv | 125 ++++++++++++
 tb/tb_alu_pipe.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_pipe.sv
// alu_pipe: pipelined integer ALU with valid/ready handshakes on both sides.
// Results, {N,V,C,Z} flags and an illegal-opcode error emerge STAGES cycles after accept.
`timescale 1ns/1ps
module alu_pipe #(
    parameter int WIDTH  = 8,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [3:0]       op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic [3:0]       flags,
    output logic             err,
    output logic [15:0]      ops_done
);
    localparam int S = $clog2(WIDTH);

    typedef enum logic [3:0] {
        OP_ADD  = 4'd0,
        OP_SUB  = 4'd1,
        OP_AND  = 4'd2,
        OP_OR   = 4'd3,
        OP_XOR  = 4'd4,
        OP_SHL  = 4'd5,
        OP_SHR  = 4'd6,
        OP_SRA  = 4'd7,
        OP_SLT  = 4'd8,
        OP_SLTU = 4'd9
    } op_e;

    typedef struct packed {
        logic             valid;
        logic [WIDTH-1:0] result;
        logic [3:0]       flags;   // {N, V, C, Z}
        logic             err;
    } beat_t;

    beat_t          stage_q [STAGES];   // element 0 is stage 1
    beat_t          compute;
    logic           adv;
    logic           accept;
    logic [WIDTH:0] sum;
    logic [WIDTH:0] diff;
    logic [S-1:0]   shamt;
    logic           carry;
    logic           ovf;

    // The extra top bit of sum is the carry-out; for diff it is the borrow (a < b unsigned).
    assign sum   = {1'b0, a} + {1'b0, b};
    assign diff  = {1'b0, a} - {1'b0, b};
    assign shamt = b[S-1:0];

    // Stalls are driven only by the last stage, so in_ready never sees in_valid or data.
    assign adv      = !stage_q[STAGES-1].valid || out_ready;
    assign in_ready = adv;
    assign accept   = in_valid && adv;

    // NOTE: every variable written here gets a default first so no latch is inferred.
    always_comb begin
        compute       = '0;
        compute.valid = accept;
        carry         = 1'b0;
        ovf           = 1'b0;
        case (op_e'(op))
            OP_ADD: begin
                compute.result = sum[WIDTH-1:0];
                carry          = sum[WIDTH];
                ovf            = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
            end
            OP_SUB: begin
                compute.result = diff[WIDTH-1:0];
                carry          = diff[WIDTH];
                ovf            = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);
            end
            OP_AND:  compute.result = a & b;
            OP_OR:   compute.result = a | b;
            OP_XOR:  compute.result = a ^ b;
            OP_SHL:  compute.result = a << shamt;
            OP_SHR:  compute.result = a >> shamt;
            OP_SRA:  compute.result = $unsigned($signed(a) >>> shamt);
            OP_SLT:  compute.result = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
            OP_SLTU: compute.result = {{(WIDTH-1){1'b0}}, (a < b)};
            default: compute.err    = 1'b1;
        endcase
        if (!compute.err) begin
            compute.flags = {compute.result[WIDTH-1], ovf, carry, (compute.result == '0)};
        end
    end

    // NOTE: data fields are reset along with the valids because result/flags/err
    // are visible outputs that must read zero out of reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < STAGES; i++) begin
                stage_q[i] <= '0;
            end
        end else if (adv) begin
            // NOTE: non-blocking assignment lets every stage read its predecessor's old value.
            stage_q[0] <= compute;
            for (int i = STAGES - 1; i > 0; i--) begin
                stage_q[i] <= stage_q[i-1];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ops_done <= '0;
        end else if (out_valid && out_ready && (ops_done != 16'hFFFF)) begin
            ops_done <= ops_done + 16'd1;
        end
    end

    assign out_valid = stage_q[STAGES-1].valid;
    assign result    = stage_q[STAGES-1].result;
    assign flags     = stage_q[STAGES-1].flags;
    assign err       = stage_q[STAGES-1].err;

endmodule

// File: tb/tb_alu_pipe.sv
// tb_alu_pipe: directed and randomized checks of alu_pipe (WIDTH=8, STAGES=2)
// using an arithmetic reference model, a scoreboard queue and a separate monitor.
`timescale 1ns/1ps
module tb_alu_pipe;
    localparam int WIDTH  = 8;
    localparam int STAGES = 2;

    typedef struct packed {
        logic [7:0] res;
        logic [3:0] flg;
        logic       err;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  a;
    logic [7:0]  b;
    logic [3:0]  op;
    logic        out_valid;
    logic        out_ready;
    logic [7:0]  result;
    logic [3:0]  flags;
    logic        err;
    logic [15:0] ops_done;

    int   checks    = 0;
    int   errors    = 0;
    int   delivered = 0;
    exp_t sb_q[$];

    alu_pipe #(.WIDTH(WIDTH), .STAGES(STAGES)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .op(op),
        .out_valid(out_valid), .out_ready(out_ready),
        .result(result), .flags(flags), .err(err),
        .ops_done(ops_done)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic int to_s(input int x);
        return (x >= 128) ? x - 256 : x;
    endfunction

    // Reference model from the opcode rules using plain integer arithmetic.
    function automatic exp_t model(input int x, input int y, input int code);
        exp_t e;
        int   r, t, p, sx, sy;
        bit   c, v;
        e  = '0;
        r  = 0;
        c  = 1'b0;
        v  = 1'b0;
        sx = to_s(x);
        sy = to_s(y);
        p  = 1 << (y % 8);
        case (code)
            0: begin
                t = x + y;
                r = t % 256;
                c = (t > 255);
                v = (sx + sy > 127) || (sx + sy < -128);
            end
            1: begin
                t = x - y;
                r = (t + 256) % 256;
                c = (x < y);
                v = (sx - sy > 127) || (sx - sy < -128);
            end
            2: r = x & y;
            3: r = x | y;
            4: r = x ^ y;
            5: r = (x * p) % 256;
            6: r = x / p;
            7: begin
                t = (sx >= 0) ? sx / p : -((-sx + p - 1) / p);
                r = (t + 256) % 256;
            end
            8: r = (sx < sy) ? 1 : 0;
            9: r = (x < y) ? 1 : 0;
            default: begin
                e.err = 1'b1;
                return e;
            end
        endcase
        e.res = r[7:0];
        e.flg = {(r >= 128), v, c, (r == 0)};
        return e;
    endfunction

    // Scoreboard producer: every accepted beat pushes its expected response.
    initial begin
        forever begin
            @(negedge clk);
            if (rst_n && in_valid && in_ready) begin
                sb_q.push_back(model(int'(a), int'(b), int'(op)));
            end
        end
    end

    // Monitor: compares delivered beats against the scoreboard and checks hold-stability.
    initial begin
        exp_t e;
        exp_t held_val;
        logic held;
        held = 1'b0;
        held_val = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                held = 1'b0;
            end else begin
                if (held) begin
                    check("hold_valid", out_valid, 1);
                    check("hold_data", {result, flags, err}, held_val);
                end
                held     = out_valid && !out_ready;
                held_val = {result, flags, err};
                if (out_valid && out_ready) begin
                    delivered++;
                    if (sb_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL sb_underflow: got result %0h expected no beat", result);
                    end else begin
                        e = sb_q.pop_front();
                        check("sb_result", result, e.res);
                        check("sb_flags", flags, e.flg);
                        check("sb_err", err, e.err);
                    end
                end
            end
        end
    end

    // Issue one beat into an empty pipeline and check its exact latency and value.
    task automatic directed(input string name, input logic [7:0] xa, input logic [7:0] xb,
                            input logic [3:0] xop, input logic [7:0] er,
                            input logic [3:0] ef, input logic ee);
        a = xa; b = xb; op = xop; in_valid = 1'b1;
        @(negedge clk);
        check({name, "_in_ready"}, in_ready, 1);
        check({name, "_lat0"}, out_valid, 0);
        @(posedge clk); #1 in_valid = 1'b0;
        @(negedge clk);
        check({name, "_lat1"}, out_valid, 0);
        @(posedge clk); #1;
        @(negedge clk);
        check({name, "_valid"}, out_valid, 1);
        check({name, "_result"}, result, er);
        check({name, "_flags"}, flags, ef);
        check({name, "_err"}, err, ee);
        @(posedge clk); #1;
    endtask

    task automatic pulse_reset();
        rst_n = 1'b0;
        #1;
        sb_q.delete();
        delivered = 0;
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    initial begin
        #500000;
        errors++;
        $display("FAIL watchdog: time limit reached expected completion");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; a = '0; b = '0; op = '0; out_ready = 1'b1;
        #1;
        check("rst_in_ready", in_ready, 1);
        check("rst_out_valid", out_valid, 0);
        check("rst_ops_done", ops_done, 0);
        check("rst_outputs", {result, flags, err}, 0);
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;

        directed("add_carry", 8'hF0, 8'h20, 4'd0, 8'h10, 4'b0010, 1'b0);
        directed("sub_ovf",   8'h80, 8'h01, 4'd1, 8'h7F, 4'b0100, 1'b0);
        directed("sub_zero",  8'h05, 8'h05, 4'd1, 8'h00, 4'b0001, 1'b0);
        directed("sra_mask",  8'h90, 8'h0A, 4'd7, 8'hE4, 4'b1000, 1'b0);
        directed("slt",       8'hFF, 8'h01, 4'd8, 8'h01, 4'b0000, 1'b0);
        directed("sltu",      8'hFF, 8'h01, 4'd9, 8'h00, 4'b0001, 1'b0);
        directed("illegal",   8'h33, 8'h44, 4'hC, 8'h00, 4'b0000, 1'b1);

        // Backpressure: two beats fill the stalled pipe, then in_ready drops.
        pulse_reset();
        out_ready = 1'b0;
        a = 8'h01; b = 8'h02; op = 4'd0; in_valid = 1'b1;
        @(negedge clk); check("bp_accept0", in_ready, 1);
        @(posedge clk); #1 a = 8'h10; b = 8'h20;
        @(negedge clk); check("bp_accept1", in_ready, 1); check("bp_valid_early", out_valid, 0);
        @(posedge clk); #1 a = 8'h7F; b = 8'h01;
        @(negedge clk);
        check("bp_in_ready_low", in_ready, 0);
        check("bp_out_valid", out_valid, 1);
        check("bp_hold_result", result, 8'h03);
        repeat (3) begin
            @(posedge clk); #1;
            @(negedge clk);
            check("bp_stall_ready", in_ready, 0);
            check("bp_stall_result", result, 8'h03);
        end
        @(posedge clk); #1 out_ready = 1'b1;
        @(negedge clk); check("bp_out0", result, 8'h03); check("bp_resume_ready", in_ready, 1);
        @(posedge clk); #1 a = 8'hFF; b = 8'h01;
        @(negedge clk); check("bp_out1", result, 8'h30); check("bp_out1_valid", out_valid, 1);
        @(posedge clk); #1 in_valid = 1'b0;
        @(negedge clk); check("bp_out2", result, 8'h80); check("bp_out2_flags", flags, 4'b1100);
        @(posedge clk); #1;
        @(negedge clk); check("bp_out3", result, 8'h00); check("bp_out3_flags", flags, 4'b0011);
        @(posedge clk); #1;
        @(negedge clk); check("bp_drained", out_valid, 0); check("bp_ops_done", ops_done, 4);
        @(posedge clk); #1;

        // Reset mid-stream with two beats in flight.
        a = 8'h11; b = 8'h22; op = 4'd0; in_valid = 1'b1;
        @(posedge clk); #1 a = 8'h01; b = 8'h01; op = 4'd1;
        @(posedge clk); #1 in_valid = 1'b0;
        check("mid_inflight", out_valid, 1);
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst_valid", out_valid, 0);
        check("mid_rst_ops", ops_done, 0);
        check("mid_rst_ready", in_ready, 1);
        sb_q.delete();
        delivered = 0;
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
        directed("post_rst", 8'h0F, 8'h01, 4'd4, 8'h0E, 4'b0000, 1'b0);

        // Randomized traffic with random backpressure.
        for (int i = 0; i < 400; i++) begin
            in_valid  = ($urandom_range(3) != 0);
            a         = 8'($urandom);
            b         = 8'($urandom);
            op        = ($urandom_range(7) == 0) ? 4'($urandom_range(15, 10)) : 4'($urandom_range(9));
            out_ready = ($urandom_range(2) != 0);
            @(posedge clk); #1;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 20 && sb_q.size() != 0; i++) begin
            @(posedge clk);
        end
        #1;
        check("drain_empty", sb_q.size(), 0);
        check("drain_out_valid", out_valid, 0);
        check("ops_done_count", ops_done, delivered);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
